// File: rtl/regfile_access_ctrl_if.sv
// Debug host side of the register file access controller: single-register
// commands, completion status and the register dump stream.
interface regfile_access_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          dbg_req;
    logic          dbg_wr;
    logic          dbg_dump;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic          dbg_err;
    logic [DW-1:0] dbg_rdata;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;

    modport master (
        output dbg_req, dbg_wr, dbg_dump, dbg_addr, dbg_wdata, dump_ready,
        input  dbg_ack, dbg_err, dbg_rdata, dump_valid, dump_idx, dump_data
    );

    modport slave (
        input  dbg_req, dbg_wr, dbg_dump, dbg_addr, dbg_wdata, dump_ready,
        output dbg_ack, dbg_err, dbg_rdata, dump_valid, dump_idx, dump_data
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Arbitrates register file ports between the pipeline and a debug host:
// stalls the pipeline, performs a single access or a full dump, then releases.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | pipeline owns the register file, waiting for dbg_req
//   S_HALT    | stall requested, waiting for stall_ack with no writeback
//   S_ACCESS  | one-cycle debug read or write
//   S_DUMP    | streaming all registers out, one beat per handshake
//   S_RELEASE | completion pulse (dbg_ack/dbg_err), stall dropped
module regfile_access_ctrl #(
    parameter int DW            = 8,
    parameter int AW            = 3,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] i_pl_ra1,
    input  logic [AW-1:0] i_pl_ra2,
    input  logic          i_pl_we,
    input  logic [AW-1:0] i_pl_wa,
    input  logic [DW-1:0] i_pl_wd,
    output logic [AW-1:0] o_rf_ra1,
    output logic [AW-1:0] o_rf_ra2,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_wa,
    output logic [DW-1:0] o_rf_wd,
    input  logic [DW-1:0] i_rf_rd2,
    output logic          o_stall_req,
    input  logic          i_stall_ack,
    regfile_access_ctrl_if.slave dbg,
    output logic          o_busy
);

    localparam int            TW       = $clog2(STALL_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(STALL_TIMEOUT - 1);
    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ACCESS,
        S_DUMP,
        S_RELEASE
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_wr;
    logic          r_dump;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_k;
    logic          r_dv;
    logic [AW-1:0] r_didx;
    logic [DW-1:0] r_ddata;

    logic          w_halt_exit;
    logic          w_last_take;

    // Leave HALT only once the pipeline is drained and no writeback is in flight.
    assign w_halt_exit = i_stall_ack && !i_pl_we;
    assign w_last_take = r_dv && dbg.dump_ready && (r_didx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        o_rf_ra1 = i_pl_ra1;
        o_rf_ra2 = i_pl_ra2;
        o_rf_we  = i_pl_we;
        o_rf_wa  = i_pl_wa;
        o_rf_wd  = i_pl_wd;
        case (r_state)
            S_IDLE: begin
                if (dbg.dbg_req) w_next = S_HALT;
            end
            S_HALT: begin
                if (w_halt_exit)          w_next = r_dump ? S_DUMP : S_ACCESS;
                else if (r_tmo == TMO_LAST) w_next = S_RELEASE;
            end
            S_ACCESS: begin
                o_rf_we  = r_wr;
                o_rf_wa  = r_addr;
                o_rf_wd  = r_wdata;
                o_rf_ra2 = r_addr;
                w_next   = S_RELEASE;
            end
            S_DUMP: begin
                o_rf_we  = 1'b0;
                o_rf_ra2 = r_k;
                if (w_last_take) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= 1'b0;
            r_dump  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_k     <= '0;
            r_dv    <= 1'b0;
            r_didx  <= '0;
            r_ddata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dbg.dbg_req) begin
                        r_wr    <= dbg.dbg_wr;
                        r_dump  <= dbg.dbg_dump;
                        r_addr  <= dbg.dbg_addr;
                        r_wdata <= dbg.dbg_wdata;
                        r_tmo   <= '0;
                        r_err   <= 1'b0;
                        r_k     <= '0;
                        r_dv    <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (!w_halt_exit) begin
                        if (r_tmo == TMO_LAST) r_err <= 1'b1;
                        else                   r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_ACCESS: begin
                    if (!r_wr) r_rdata <= i_rf_rd2;
                end
                S_DUMP: begin
                    // r_k runs one ahead of the presented beat so the next
                    // register is already addressed when the current one is taken.
                    if (w_last_take) begin
                        r_dv <= 1'b0;
                    end else if (!r_dv || dbg.dump_ready) begin
                        r_dv    <= 1'b1;
                        r_didx  <= r_k;
                        r_ddata <= i_rf_rd2;
                        r_k     <= r_k + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_stall_req    = (r_state == S_HALT) || (r_state == S_ACCESS) || (r_state == S_DUMP);
    assign o_busy         = (r_state != S_IDLE);
    assign dbg.dbg_ack    = (r_state == S_RELEASE);
    assign dbg.dbg_err    = (r_state == S_RELEASE) && r_err;
    assign dbg.dbg_rdata  = r_rdata;
    assign dbg.dump_valid = r_dv;
    assign dbg.dump_idx   = r_didx;
    assign dbg.dump_data  = r_ddata;

endmodule
